// File: rtl/sy_ppl_fpu_mq.sv
// FPU mapping queue: tags in-flight FPU ops with their destination and ROB
// slot, then retires each result through a one-cycle writeback/commit stage.
module sy_ppl_fpu_mq #(
  parameter int DWTH        = 64,
  parameter int PHY_REG_WTH = 6,
  parameter int ROB_WTH     = 6,
  parameter int DEPTH       = 4,
  localparam int TWTH       = $clog2(DEPTH),
  localparam int CWTH       = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   fpu_en_i,
  output logic                   fpu_ready_o,
  input  logic [PHY_REG_WTH-1:0] fpu_rdst_idx_i,
  input  logic                   fpu_rdst_is_fp_i,
  input  logic [ROB_WTH-1:0]     fpu_rob_idx_i,
  output logic                   core_vld_o,
  input  logic                   core_rdy_i,
  output logic [TWTH-1:0]        core_tid_o,
  input  logic                   core_res_vld_i,
  input  logic [TWTH-1:0]        core_tid_i,
  input  logic [DWTH-1:0]        core_res_i,
  input  logic [4:0]             core_status_i,
  output logic                   fpr_wr_en_o,
  output logic                   gpr_wr_en_o,
  output logic [PHY_REG_WTH-1:0] fpr_wr_idx_o,
  output logic [PHY_REG_WTH-1:0] gpr_wr_idx_o,
  output logic [DWTH-1:0]        fpr_wr_data_o,
  output logic [DWTH-1:0]        gpr_wr_data_o,
  output logic                   commit_vld_o,
  output logic [ROB_WTH-1:0]     commit_rob_idx_o,
  output logic [4:0]             commit_status_o,
  output logic                   commit_flush_en_o,
  output logic                   awake_vld_o,
  output logic [PHY_REG_WTH-1:0] awake_idx_o,
  output logic                   awake_is_fp_o,
  output logic                   fpu_busy_o,
  output logic [CWTH-1:0]        outstanding_o,
  output logic                   spurious_o
);

  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [DEPTH-1:0]       is_fp_q;
  logic [PHY_REG_WTH-1:0] rdst_q [DEPTH];
  logic [ROB_WTH-1:0]     rob_q  [DEPTH];
  logic [CWTH-1:0]        cnt_q, cnt_d;
  logic [TWTH-1:0]        free_idx;
  logic                   full, issue_acc, tid_vld, res_hit;

  logic                   wb_vld_q, wb_is_fp_q, spurious_q;
  logic [PHY_REG_WTH-1:0] wb_rdst_q;
  logic [ROB_WTH-1:0]     wb_rob_q;
  logic [DWTH-1:0]        wb_data_q;
  logic [4:0]             wb_status_q;

  assign full        = &vld_q;
  assign fpu_ready_o = core_rdy_i & ~full & ~flush_i;
  assign core_vld_o  = fpu_en_i & ~full & ~flush_i;
  assign core_tid_o  = free_idx;
  assign issue_acc   = fpu_en_i & fpu_ready_o;
  assign tid_vld     = vld_q[core_tid_i];
  assign res_hit     = core_res_vld_i & tid_vld & ~flush_i;

  // Scan downward so the lowest free entry wins.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = TWTH'(i);
    end
  end

  // Issue targets an invalid entry and a hit targets a valid one, so they never collide.
  always_comb begin
    vld_d = vld_q;
    if (issue_acc) vld_d[free_idx] = 1'b1;
    if (res_hit) vld_d[core_tid_i] = 1'b0;
    if (flush_i) vld_d = '0;
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CWTH'(vld_d[i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q       <= '0;
      is_fp_q     <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdst_q[i] <= '0;
        rob_q[i]  <= '0;
      end
      wb_vld_q    <= 1'b0;
      wb_is_fp_q  <= 1'b0;
      wb_rdst_q   <= '0;
      wb_rob_q    <= '0;
      wb_data_q   <= '0;
      wb_status_q <= '0;
      spurious_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      if (issue_acc) begin
        rdst_q[free_idx]  <= fpu_rdst_idx_i;
        is_fp_q[free_idx] <= fpu_rdst_is_fp_i;
        rob_q[free_idx]   <= fpu_rob_idx_i;
      end
      wb_vld_q <= res_hit;
      if (res_hit) begin
        wb_is_fp_q  <= is_fp_q[core_tid_i];
        wb_rdst_q   <= rdst_q[core_tid_i];
        wb_rob_q    <= rob_q[core_tid_i];
        wb_data_q   <= core_res_i;
        wb_status_q <= core_status_i;
      end
      spurious_q <= core_res_vld_i & ~tid_vld & ~flush_i;
    end
  end

  assign gpr_wr_en_o       = wb_vld_q & ~wb_is_fp_q;
  assign fpr_wr_en_o       = wb_vld_q & wb_is_fp_q;
  assign gpr_wr_idx_o      = wb_rdst_q;
  assign fpr_wr_idx_o      = wb_rdst_q;
  assign gpr_wr_data_o     = wb_data_q;
  assign fpr_wr_data_o     = wb_data_q;
  assign commit_vld_o      = wb_vld_q;
  assign commit_rob_idx_o  = wb_rob_q;
  assign commit_status_o   = wb_status_q;
  assign commit_flush_en_o = 1'b1;
  assign awake_vld_o       = wb_vld_q;
  assign awake_idx_o       = wb_rdst_q;
  assign awake_is_fp_o     = wb_is_fp_q;
  assign outstanding_o     = cnt_q;
  assign fpu_busy_o        = (cnt_q != '0);
  assign spurious_o        = spurious_q;

endmodule

// File: tb/tb_sy_ppl_fpu_mq.sv
// Directed self-checking bench for sy_ppl_fpu_mq (default parameters).
module tb_sy_ppl_fpu_mq;
  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, fpu_en_i, fpu_ready_o;
  logic [5:0]  fpu_rdst_idx_i;
  logic        fpu_rdst_is_fp_i;
  logic [5:0]  fpu_rob_idx_i;
  logic        core_vld_o, core_rdy_i;
  logic [1:0]  core_tid_o, core_tid_i;
  logic        core_res_vld_i;
  logic [63:0] core_res_i;
  logic [4:0]  core_status_i;
  logic        fpr_wr_en_o, gpr_wr_en_o;
  logic [5:0]  fpr_wr_idx_o, gpr_wr_idx_o;
  logic [63:0] fpr_wr_data_o, gpr_wr_data_o;
  logic        commit_vld_o;
  logic [5:0]  commit_rob_idx_o;
  logic [4:0]  commit_status_o;
  logic        commit_flush_en_o, awake_vld_o;
  logic [5:0]  awake_idx_o;
  logic        awake_is_fp_o, fpu_busy_o;
  logic [2:0]  outstanding_o;
  logic        spurious_o;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_rdst [4];
  logic       exp_fp   [4];
  logic [5:0] exp_rob  [4];

  always #5 clk_i = ~clk_i;

  sy_ppl_fpu_mq dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .fpu_en_i(fpu_en_i), .fpu_ready_o(fpu_ready_o),
    .fpu_rdst_idx_i(fpu_rdst_idx_i), .fpu_rdst_is_fp_i(fpu_rdst_is_fp_i),
    .fpu_rob_idx_i(fpu_rob_idx_i),
    .core_vld_o(core_vld_o), .core_rdy_i(core_rdy_i), .core_tid_o(core_tid_o),
    .core_res_vld_i(core_res_vld_i), .core_tid_i(core_tid_i),
    .core_res_i(core_res_i), .core_status_i(core_status_i),
    .fpr_wr_en_o(fpr_wr_en_o), .gpr_wr_en_o(gpr_wr_en_o),
    .fpr_wr_idx_o(fpr_wr_idx_o), .gpr_wr_idx_o(gpr_wr_idx_o),
    .fpr_wr_data_o(fpr_wr_data_o), .gpr_wr_data_o(gpr_wr_data_o),
    .commit_vld_o(commit_vld_o), .commit_rob_idx_o(commit_rob_idx_o),
    .commit_status_o(commit_status_o), .commit_flush_en_o(commit_flush_en_o),
    .awake_vld_o(awake_vld_o), .awake_idx_o(awake_idx_o),
    .awake_is_fp_o(awake_is_fp_o), .fpu_busy_o(fpu_busy_o),
    .outstanding_o(outstanding_o), .spurious_o(spurious_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_issue(input logic [5:0] rd, input logic fp, input logic [5:0] rob);
    fpu_en_i = 1'b1; fpu_rdst_idx_i = rd; fpu_rdst_is_fp_i = fp; fpu_rob_idx_i = rob;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 0; fpu_en_i = 0; core_rdy_i = 0; core_res_vld_i = 0;
    core_tid_i = 0; core_res_i = 0; core_status_i = 0;
    fpu_rdst_idx_i = 0; fpu_rdst_is_fp_i = 0; fpu_rob_idx_i = 0;
    step(); step();
    rst_i = 1'b0; #1;
    checks++;
    if ({fpr_wr_en_o, gpr_wr_en_o, commit_vld_o, awake_vld_o, spurious_o, fpu_busy_o} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0",
        {fpr_wr_en_o, gpr_wr_en_o, commit_vld_o, awake_vld_o, spurious_o, fpu_busy_o});
    end
    checks++;
    if (outstanding_o !== 3'd0 || commit_flush_en_o !== 1'b1) begin
      errors++; $display("FAIL reset_cnt got %0d/%b exp 0/1", outstanding_o, commit_flush_en_o);
    end
    checks++;
    if ({fpr_wr_idx_o, gpr_wr_idx_o, fpr_wr_data_o, gpr_wr_data_o, commit_rob_idx_o,
         commit_status_o, awake_idx_o, awake_is_fp_o} !== '0) begin
      errors++; $display("FAIL reset_fields got nonzero idx/data %0h exp 0", fpr_wr_data_o);
    end
    fpu_en_i = 1'b1; #1;
    checks++;
    if (fpu_ready_o !== 1'b0 || core_vld_o !== 1'b1 || core_tid_o !== 2'd0) begin
      errors++; $display("FAIL reset_rdy got rdy=%b vld=%b tid=%0d exp 0 1 0",
        fpu_ready_o, core_vld_o, core_tid_o);
    end
    fpu_en_i = 1'b0;
    step();
    checks++;
    if (outstanding_o !== 3'd0) begin
      errors++; $display("FAIL no_rdy_issue got %0d exp 0", outstanding_o);
    end
  endtask

  task automatic test_single();
    core_rdy_i = 1'b1;
    set_issue(6'd5, 1'b1, 6'd3); #1;
    checks++;
    if (fpu_ready_o !== 1'b1 || core_vld_o !== 1'b1 || core_tid_o !== 2'd0) begin
      errors++; $display("FAIL single_issue got rdy=%b vld=%b tid=%0d exp 1 1 0",
        fpu_ready_o, core_vld_o, core_tid_o);
    end
    step(); fpu_en_i = 1'b0;
    checks++;
    if (outstanding_o !== 3'd1 || fpu_busy_o !== 1'b1) begin
      errors++; $display("FAIL single_cnt got %0d busy=%b exp 1 1", outstanding_o, fpu_busy_o);
    end
    step();
    core_res_vld_i = 1'b1; core_tid_i = 2'd0;
    core_res_i = 64'h3FF0_0000_0000_0000; core_status_i = 5'h04;
    step(); core_res_vld_i = 1'b0;
    checks++;
    if (fpr_wr_en_o !== 1'b1 || gpr_wr_en_o !== 1'b0 || fpr_wr_idx_o !== 6'd5 ||
        fpr_wr_data_o !== 64'h3FF0_0000_0000_0000) begin
      errors++; $display("FAIL single_wb got fpr=%b gpr=%b idx=%0d data=%0h exp 1 0 5 3ff0000000000000",
        fpr_wr_en_o, gpr_wr_en_o, fpr_wr_idx_o, fpr_wr_data_o);
    end
    checks++;
    if (commit_vld_o !== 1'b1 || commit_rob_idx_o !== 6'd3 || commit_status_o !== 5'h04 ||
        awake_vld_o !== 1'b1 || awake_idx_o !== 6'd5 || awake_is_fp_o !== 1'b1) begin
      errors++; $display("FAIL single_commit got vld=%b rob=%0d st=%0h awake=%b/%0d exp 1 3 4 1/5",
        commit_vld_o, commit_rob_idx_o, commit_status_o, awake_vld_o, awake_idx_o);
    end
    checks++;
    if (outstanding_o !== 3'd0 || fpu_busy_o !== 1'b0) begin
      errors++; $display("FAIL single_free got %0d exp 0", outstanding_o);
    end
    step();
    checks++;
    if (commit_vld_o !== 1'b0 || fpr_wr_en_o !== 1'b0) begin
      errors++; $display("FAIL single_pulse got commit=%b exp 0", commit_vld_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      exp_rdst[i] = 6'(10 + i); exp_fp[i] = i[0]; exp_rob[i] = 6'(20 + i);
      set_issue(exp_rdst[i], exp_fp[i], exp_rob[i]); #1;
      checks++;
      if (core_tid_o !== 2'(i) || fpu_ready_o !== 1'b1) begin
        errors++; $display("FAIL b2b_tid%0d got tid=%0d rdy=%b exp %0d 1", i, core_tid_o, fpu_ready_o, i);
      end
      step();
    end
    set_issue(6'd30, 1'b0, 6'd31); #1;
    checks++;
    if (fpu_ready_o !== 1'b0 || core_vld_o !== 1'b0 || outstanding_o !== 3'd4) begin
      errors++; $display("FAIL b2b_full got rdy=%b vld=%b cnt=%0d exp 0 0 4",
        fpu_ready_o, core_vld_o, outstanding_o);
    end
    step();
    checks++;
    if (outstanding_o !== 3'd4 || fpu_ready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_hold got cnt=%0d rdy=%b exp 4 0", outstanding_o, fpu_ready_o);
    end
    core_res_vld_i = 1'b1; core_tid_i = 2'd1; core_res_i = 64'h55; core_status_i = 5'h1; #1;
    checks++;
    if (fpu_ready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_nobypass got rdy=%b exp 0", fpu_ready_o);
    end
    step(); core_res_vld_i = 1'b0; #1;
    checks++;
    if (fpu_ready_o !== 1'b1 || core_tid_o !== 2'd1 || outstanding_o !== 3'd3 ||
        commit_rob_idx_o !== 6'd21 || fpr_wr_en_o !== 1'b1) begin
      errors++; $display("FAIL b2b_release got rdy=%b tid=%0d cnt=%0d rob=%0d exp 1 1 3 21",
        fpu_ready_o, core_tid_o, outstanding_o, commit_rob_idx_o);
    end
    exp_rdst[1] = 6'd30; exp_fp[1] = 1'b0; exp_rob[1] = 6'd31;
    step(); fpu_en_i = 1'b0;
    checks++;
    if (outstanding_o !== 3'd4) begin
      errors++; $display("FAIL b2b_fifth got cnt=%0d exp 4", outstanding_o);
    end
  endtask

  task automatic test_out_of_order();
    logic [1:0] order [4];
    order[0] = 2'd2; order[1] = 2'd0; order[2] = 2'd3; order[3] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      core_res_vld_i = 1'b1; core_tid_i = order[k];
      core_res_i = 64'hA000 + 64'(k); core_status_i = 5'(k + 8);
      step();
      checks++;
      if (commit_vld_o !== 1'b1 || commit_rob_idx_o !== exp_rob[order[k]] ||
          commit_status_o !== 5'(k + 8) || awake_idx_o !== exp_rdst[order[k]] ||
          fpr_wr_en_o !== exp_fp[order[k]] || gpr_wr_en_o !== !exp_fp[order[k]] ||
          gpr_wr_data_o !== 64'hA000 + 64'(k) || gpr_wr_idx_o !== exp_rdst[order[k]]) begin
        errors++; $display("FAIL ooo_wb%0d got rob=%0d rd=%0d fpr=%b data=%0h exp rob=%0d rd=%0d fpr=%b data=%0h",
          k, commit_rob_idx_o, awake_idx_o, fpr_wr_en_o, gpr_wr_data_o,
          exp_rob[order[k]], exp_rdst[order[k]], exp_fp[order[k]], 64'hA000 + 64'(k));
      end
    end
    core_res_vld_i = 1'b0;
    checks++;
    if (outstanding_o !== 3'd0 || fpu_busy_o !== 1'b0) begin
      errors++; $display("FAIL ooo_drain got cnt=%0d exp 0", outstanding_o);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set_issue(6'(40 + i), 1'b0, 6'(i)); step();
    end
    fpu_en_i = 1'b0;
    flush_i = 1'b1; fpu_en_i = 1'b1; core_res_vld_i = 1'b1; core_tid_i = 2'd1; #1;
    checks++;
    if (fpu_ready_o !== 1'b0 || core_vld_o !== 1'b0) begin
      errors++; $display("FAIL flush_block got rdy=%b vld=%b exp 0 0", fpu_ready_o, core_vld_o);
    end
    step(); flush_i = 1'b0; core_res_vld_i = 1'b0; fpu_en_i = 1'b0; #1;
    checks++;
    if (commit_vld_o !== 1'b0 || gpr_wr_en_o !== 1'b0 || outstanding_o !== 3'd0 ||
        spurious_o !== 1'b0) begin
      errors++; $display("FAIL flush_drop got commit=%b gpr=%b cnt=%0d sp=%b exp 0 0 0 0",
        commit_vld_o, gpr_wr_en_o, outstanding_o, spurious_o);
    end
    set_issue(6'd50, 1'b0, 6'd9); #1;
    checks++;
    if (core_tid_o !== 2'd0) begin
      errors++; $display("FAIL flush_tid got %0d exp 0", core_tid_o);
    end
    step(); fpu_en_i = 1'b0;
    core_res_vld_i = 1'b1; core_tid_i = 2'd0;
    step(); core_res_vld_i = 1'b0;
    checks++;
    if (commit_rob_idx_o !== 6'd9 || outstanding_o !== 3'd0) begin
      errors++; $display("FAIL flush_after got rob=%0d cnt=%0d exp 9 0", commit_rob_idx_o, outstanding_o);
    end
    step();
  endtask

  task automatic test_spurious();
    core_res_vld_i = 1'b1; core_tid_i = 2'd3;
    step(); core_res_vld_i = 1'b0;
    checks++;
    if (spurious_o !== 1'b1 || gpr_wr_en_o !== 1'b0 || fpr_wr_en_o !== 1'b0 ||
        commit_vld_o !== 1'b0 || awake_vld_o !== 1'b0) begin
      errors++; $display("FAIL spurious got sp=%b commit=%b awake=%b exp 1 0 0",
        spurious_o, commit_vld_o, awake_vld_o);
    end
    step();
    checks++;
    if (spurious_o !== 1'b0) begin
      errors++; $display("FAIL spurious_pulse got %b exp 0", spurious_o);
    end
  endtask

  task automatic test_reset_midflight();
    set_issue(6'd7, 1'b1, 6'd17); step();
    set_issue(6'd8, 1'b0, 6'd18); step();
    fpu_en_i = 1'b0;
    rst_i = 1'b1; core_res_vld_i = 1'b1; core_tid_i = 2'd1; core_res_i = 64'hDEAD;
    step(); rst_i = 1'b0; core_res_vld_i = 1'b0;
    checks++;
    if ({fpr_wr_en_o, gpr_wr_en_o, commit_vld_o, awake_vld_o, spurious_o, fpu_busy_o} !== 6'b0 ||
        outstanding_o !== 3'd0 || commit_flush_en_o !== 1'b1 ||
        {gpr_wr_data_o, commit_rob_idx_o, awake_idx_o} !== '0) begin
      errors++; $display("FAIL rst_mid got cnt=%0d commit=%b data=%0h exp 0 0 0",
        outstanding_o, commit_vld_o, gpr_wr_data_o);
    end
    core_res_vld_i = 1'b1; core_tid_i = 2'd0;
    step(); core_res_vld_i = 1'b0;
    checks++;
    if (spurious_o !== 1'b1 || fpr_wr_en_o !== 1'b0 || commit_vld_o !== 1'b0) begin
      errors++; $display("FAIL rst_spurious got sp=%b fpr=%b exp 1 0", spurious_o, fpr_wr_en_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_order();
    test_flush();
    test_spurious();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
